// File: rtl/risc_pkg.sv
// Shared RV32I definitions: opcode constants used by the loader's opcode filter
// and the core's main decoder, plus the imem loader state encoding.
package risc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_DONE,
    LD_ERR
  } ld_state_e;

  // True for the opcodes the core's main decoder implements.
  function automatic logic opcode_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: ok = 1'b1;
      default:                                                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/risc_word_packer.sv
// Packs four consecutive bytes little-endian into one 32-bit word;
// word_valid flags the cycle in which the fourth byte is accepted.
module risc_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic        word_valid
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clear) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (byte_en) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_in;
      idx_q                        <= idx_q + 2'd1;
    end
  end

  assign word       = word_q;
  assign byte_idx   = idx_q;
  assign word_valid = byte_en && (idx_q == 2'd3);

endmodule

// File: rtl/risc_imem_loader.sv
// Instruction-memory loader: byte stream -> packed RV32I words -> sequential imem writes,
// holding the core in reset until loaded. Optional opcode filter: RISC_OPCODE_CHECK_EN.
module risc_imem_loader
  import risc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  ld_state_e       state_q, state_d;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] cnt_next;
  logic            core_rst_n_q;
  logic            load_start;
  logic            cnt_inc;
  logic            byte_fire;
  logic            op_ok;
  logic [31:0]     pack_word;
  logic [1:0]      pack_idx;
  logic            pack_valid;

  // Kept outside the FSM process so the packer's word_valid feedback is not a comb loop.
  assign byte_fire = s_valid && (state_q == LD_RECV);
  assign cnt_next  = cnt_q + 1'b1;

  risc_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (load_start),
    .byte_en    (byte_fire),
    .byte_in    (s_data),
    .word       (pack_word),
    .byte_idx   (pack_idx),
    .word_valid (pack_valid)
  );

`ifdef RISC_OPCODE_CHECK_EN
  assign op_ok = opcode_legal(pack_word[6:0]);
`else
  assign op_ok = 1'b1;
`endif

  // NOTE: every output of this process gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          load_start = 1'b1;
          if (len_words == '0)          state_d = LD_DONE;
          else if (len_words > CAPACITY) state_d = LD_ERR;
          else                          state_d = LD_RECV;
        end
      end
      LD_RECV: begin
        if (pack_valid) state_d = LD_WRITE;
      end
      LD_WRITE: begin
        if (op_ok) begin
          cnt_inc = 1'b1;
          state_d = (cnt_next == len_q) ? LD_DONE : LD_RECV;
        end else begin
          state_d = LD_ERR;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LD_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_start) begin
        len_q <= len_words;
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_next;
      end
      // Registered from the next state so core reset releases exactly on DONE entry
      // and reasserts on the edge that leaves DONE, with no decode glitches.
      core_rst_n_q <= (state_d == LD_DONE);
    end
  end

  assign s_ready    = (state_q == LD_RECV);
  assign imem_we    = (state_q == LD_WRITE) && op_ok;
  assign imem_addr  = cnt_q[ADDR_W-1:0];
  assign imem_wdata = pack_word;
  assign core_rst_n = core_rst_n_q;
  assign busy       = (state_q == LD_RECV) || (state_q == LD_WRITE);
  assign done       = (state_q == LD_DONE);
  assign err        = (state_q == LD_ERR);
  assign word_cnt   = cnt_q;

endmodule

// File: doc/risc_imem_loader.md
Name: risc_imem_loader

Overview:
- Write side of instruction memory: receives a byte stream, packs it little-endian into 32-bit RV32I words, and writes them to sequential imem word addresses.
- Holds the pipelined core in reset until the programmed number of words has been loaded; fetch and the control-path decoder then read the loaded image.
- Optionally rejects words whose opcode the core's main decoder does not support.

Parameters:
- ADDR_W, 8, imem word-address width; capacity 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load; sampled only in IDLE, DONE, ERR
- len_words  in  ADDR_W+1  number of words to load; sampled on accepted start
- s_valid  in  1  byte-stream valid
- s_data  in  8  byte-stream data
- s_ready  out  1  byte-stream ready
- imem_we  out  1  imem write strobe, one cycle per word
- imem_addr  out  ADDR_W  imem word address
- imem_wdata  out  32  imem write data
- core_rst_n  out  1  active-low reset to the core
- busy  out  1  load in progress
- done  out  1  load completed successfully; sticky until next start
- err  out  1  load aborted; sticky until next start
- word_cnt  out  ADDR_W+1  words written so far

Behaviour:
- Reset values: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, err=0, word_cnt=0, byte index=0, FSM=IDLE. Asserting rst_n mid-load aborts the load immediately. No partial word is written.
- FSM states: IDLE, RECV, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Latch len_words. Clear word_cnt, byte index, done and err. Drive core_rst_n=0.
  - If len_words==0, go to DONE. If len_words > 2**ADDR_W, go to ERR.
  - Otherwise go to RECV.
- Start arriving in RECV or WRITE is ignored.
- RECV:
  - s_ready=1. A byte transfers when s_valid && s_ready.
  - Byte k (k=0..3) is stored in word bits [8k+7:8k].
  - On the transfer of byte 3, go to WRITE on the next cycle. s_ready=0 in every state except RECV.
- WRITE: exactly one cycle.
  - imem_we=1, imem_addr=word_cnt[ADDR_W-1:0], imem_wdata=the packed word.
  - Next cycle: word_cnt increments. If the new word_cnt==len, go to DONE; otherwise return to RECV with byte index 0.
- Latency: imem_we is asserted the cycle after byte 3 is accepted. Minimum cadence is 5 cycles per word.
- DONE: done=1, core_rst_n=1, busy=0.
- ERR: err=1, core_rst_n stays 0, busy=0.
- busy=1 in RECV and WRITE.
- imem_addr never wraps; the length check at start guarantees it.
- s_valid deasserting between bytes only stalls the load; there is no timeout.
- core_rst_n is a registered output, glitch-free, and changes only on a clk edge (except at async reset assertion).

Optional Feature:
- Macro: RISC_OPCODE_CHECK_EN.
- With the macro defined, WRITE inspects wdata[6:0]. Legal opcodes: 0000011, 0100011, 0110011, 0010011, 1100011, 1101111.
  - Illegal opcode: suppress imem_we, leave word_cnt unchanged, go to ERR.
- Without the macro, every word is written unconditionally and err is set only by a length overflow.

Decomposition:
- Shared package risc_pkg holds:
  - Opcode localparams: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL.
  - Loader state encoding.
  - The main decoder reuses the same opcode constants.
- One sub-module: risc_word_packer (byte index counter plus 32-bit shift/assemble register, with clear and word_valid outputs). The FSM, address counter and opcode check stay in the top.

Test Plan:
- Basic load: ADDR_W=8, start with len=2, stream 13 05 A0 00 93 05 B0 00 with continuous valid -> writes addr0=0x00A00513 and addr1=0x00B00593, then done=1, core_rst_n=1, word_cnt=2.
- Backpressure/gaps: same stream with s_valid toggling randomly -> identical writes, exactly 2 imem_we pulses, no byte lost or duplicated.
- Zero and overflow: start len=0 -> done next cycle with no writes. Start len=257 -> err=1, core_rst_n=0, no writes.
- Illegal opcode (RISC_OPCODE_CHECK_EN defined): word 0xFFFFFFFF as the 2nd of 3 -> addr0 written, no 2nd write, err=1, word_cnt=1. Without the macro, all 3 are written and done=1.
- Reset mid-load: pulse rst_n low after byte 2 of word 1 -> all outputs return to reset values. A fresh load of 1 word then writes addr0 correctly.
- Restart: start in DONE -> core_rst_n drops the next cycle and done clears; start pulsed during RECV is ignored.
